// File: rtl/program_counter_pkg.sv
// program_counter_pkg: shared defaults and legal width range for the program counter
package program_counter_pkg;
  localparam int PC_WIDTH_DEFAULT     = 8;
  localparam int PC_RESET_VEC_DEFAULT = 0;
  localparam int PC_WIDTH_MIN         = 2;
  localparam int PC_WIDTH_MAX         = 16;
endpackage

// File: rtl/program_counter_incrementer_n.sv
// incrementer_n: ripple half-adder chain adding one to a_i, with carry-out
module incrementer_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  output wire  [WIDTH-1:0] sum_o,
  output wire              co_o
);
  wire [WIDTH:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    xor u_s (sum_o[i], a_i[i], c[i]);
    and u_c (c[i+1], a_i[i], c[i]);
  end
  assign co_o = c[WIDTH];
endmodule

// File: rtl/program_counter.sv
// program_counter: registered PC with reset > load > inc > hold priority
// Optional pc_wrap pulse output when PC_WRAP_FLAG_EN is defined.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int          WIDTH     = PC_WIDTH_DEFAULT,
  parameter int unsigned RESET_VEC = PC_RESET_VEC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] pc_load_val,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] pc_out
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             pc_wrap
`endif
);
  localparam logic [WIDTH-1:0] RV = RESET_VEC[WIDTH-1:0];
  logic [WIDTH-1:0] pc_q;
  wire  [WIDTH-1:0] pc_d;
  wire  [WIDTH-1:0] sum;
  wire              co;
  wire              n_ld, n_inc, sel_inc, sel_hold;
  incrementer_n #(.WIDTH(WIDTH)) u_inc (
    .a_i  (pc_q),
    .sum_o(sum),
    .co_o (co)
  );
  not u_nld  (n_ld, pc_load);
  not u_ninc (n_inc, pc_inc);
  and u_sinc (sel_inc, n_ld, pc_inc);
  and u_shld (sel_hold, n_ld, n_inc);
  // one-hot select of load / increment / hold, OR-combined per bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    wire t_ld, t_inc, t_hld;
    and u_ld  (t_ld, pc_load, pc_load_val[i]);
    and u_in  (t_inc, sel_inc, sum[i]);
    and u_hd  (t_hld, sel_hold, pc_q[i]);
    or  u_or  (pc_d[i], t_ld, t_inc, t_hld);
  end
  always_ff @(posedge clk)
    pc_q <= reset ? RV : pc_d;
  assign pc_out = pc_q;
`ifdef PC_WRAP_FLAG_EN
  logic wrap_q;
  wire  wrap_d;
  and u_wrap (wrap_d, sel_inc, co);
  always_ff @(posedge clk)
    wrap_q <= reset ? 1'b0 : wrap_d;
  assign pc_wrap = wrap_q;
`else
  wire unused_co;
  assign unused_co = co;
`endif
endmodule
